// File: rtl/npc_axi_ram_if.sv
// AXI4 bus bundle (AR/R/AW/W/B) shared by the RAM slave and whoever drives it.
interface axi_if #(
  parameter int DATA_W = 64
);
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/npc_axi_ram.sv
// AXI4 RAM slave with independent read and write FSMs and FIXED/INCR/WRAP bursts.
// Optional macro NPC_RAM_RAND_DELAY_EN adds LFSR-driven 0-7 cycle stalls before
// each R beat and before bvalid; without it every beat is presented back to back.
module npc_axi_ram #(
  parameter int          DATA_W     = 64,
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [31:0] BASE       = 32'h8000_0000
) (
  input  logic clk,
  input  logic rst,
  axi_if.slave in
);
  localparam int          BYTES = DATA_W / 8;
  localparam int          OFFW  = $clog2(BYTES);
  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << OFFW;

  typedef enum logic       {R_IDLE, R_DATA} rState_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic inRange(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return (a >= BASE) && (off < SPAN);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] wordIdx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[OFFW +: DEPTH_LOG2];
  endfunction

  // WRAP only wraps for the legal power-of-two lengths; other lengths fall back to INCR.
  function automatic logic [31:0] nextAddr(input logic [31:0] a, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    logic [31:0] res;
    step = 32'd1 << size;
    mask = ((32'(len) + 32'd1) << size) - 32'd1;
    res  = a + step;
    if (burst == 2'b00) begin
      res = a;
    end else if (burst == 2'b10 &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      res = (a & ~mask) | ((a + step) & mask);
    end
    return res;
  endfunction

  rState_t           rState_q, rState_d;
  logic [31:0]       rAddr_q, rAddr_d, rNext;
  logic [7:0]        rLen_q, rLen_d, rCnt_q, rCnt_d;
  logic [2:0]        rSize_q, rSize_d;
  logic [1:0]        rBurst_q, rBurst_d, rResp_q, rResp_d;
  logic [DATA_W-1:0] rData_q, rData_d;

  wState_t           wState_q, wState_d;
  logic [31:0]       wAddr_q, wAddr_d;
  logic [7:0]        wLen_q, wLen_d;
  logic [2:0]        wSize_q, wSize_d;
  logic [1:0]        wBurst_q, wBurst_d, bResp_q, bResp_d;
  logic [8:0]        wBeats_q, wBeats_d, wBeatsNext;
  logic              wErr_q, wErr_d, wBeatInRange, memWe;

  logic              arHs, rHs, wHs, bHs, rBeatOk, bBeatOk;

  assign arHs = in.arvalid & in.arready;
  assign rHs  = in.rvalid & in.rready;
  assign wHs  = in.wvalid & in.wready;
  assign bHs  = in.bvalid & in.bready;

  assign in.arready = (rState_q == R_IDLE);
  assign in.rvalid  = (rState_q == R_DATA) & rBeatOk;
  assign in.rlast   = (rState_q == R_DATA) & (rCnt_q == 8'd0);
  assign in.rdata   = rData_q;
  assign in.rresp   = rResp_q;

  assign in.awready = (wState_q == W_IDLE);
  assign in.wready  = (wState_q == W_DATA);
  assign in.bvalid  = (wState_q == W_RESP) & bBeatOk;
  assign in.bresp   = bResp_q;

`ifdef NPC_RAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  logic [2:0]  rDelay_q, bDelay_q;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying the stall lengths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Stall counters: reloaded whenever a new R beat or B response is about to be offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rDelay_q <= 3'd0;
      bDelay_q <= 3'd0;
    end else begin
      if (arHs || (rHs && !in.rlast))                   rDelay_q <= lfsr_q[2:0];
      else if (rState_q == R_DATA && rDelay_q != 3'd0) rDelay_q <= rDelay_q - 3'd1;
      if (wHs && in.wlast)                              bDelay_q <= lfsr_q[2:0];
      else if (wState_q == W_RESP && bDelay_q != 3'd0) bDelay_q <= bDelay_q - 3'd1;
    end
  end

  assign rBeatOk = (rDelay_q == 3'd0);
  assign bBeatOk = (bDelay_q == 3'd0);
`else
  assign rBeatOk = 1'b1;
  assign bBeatOk = 1'b1;
`endif

  // Read FSM: the data for the next beat is fetched into rData_q at the handshake
  // that precedes it, so rdata is registered and stable while the master stalls.
  always_comb begin
    rState_d = rState_q;
    rAddr_d  = rAddr_q;
    rLen_d   = rLen_q;
    rSize_d  = rSize_q;
    rBurst_d = rBurst_q;
    rCnt_d   = rCnt_q;
    rData_d  = rData_q;
    rResp_d  = rResp_q;
    rNext    = nextAddr(rAddr_q, rLen_q, rSize_q, rBurst_q);
    case (rState_q)
      R_IDLE: begin
        if (in.arvalid) begin
          rState_d = R_DATA;
          rAddr_d  = in.araddr;
          rLen_d   = in.arlen;
          rSize_d  = in.arsize;
          rBurst_d = in.arburst;
          rCnt_d   = in.arlen;
          rData_d  = inRange(in.araddr) ? mem[wordIdx(in.araddr)] : '0;
          rResp_d  = inRange(in.araddr) ? 2'b00 : 2'b10;
        end
      end
      R_DATA: begin
        if (rHs) begin
          if (rCnt_q == 8'd0) begin
            rState_d = R_IDLE;
          end else begin
            rAddr_d = rNext;
            rCnt_d  = rCnt_q - 8'd1;
            rData_d = inRange(rNext) ? mem[wordIdx(rNext)] : '0;
            rResp_d = inRange(rNext) ? 2'b00 : 2'b10;
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // Write FSM: tracks beat count and range errors so the B response can flag bad bursts.
  always_comb begin
    wState_d     = wState_q;
    wAddr_d      = wAddr_q;
    wLen_d       = wLen_q;
    wSize_d      = wSize_q;
    wBurst_d     = wBurst_q;
    wBeats_d     = wBeats_q;
    wErr_d       = wErr_q;
    bResp_d      = bResp_q;
    memWe        = 1'b0;
    wBeatInRange = inRange(wAddr_q);
    wBeatsNext   = (wBeats_q == 9'h1FF) ? wBeats_q : wBeats_q + 9'd1;
    case (wState_q)
      W_IDLE: begin
        if (in.awvalid) begin
          wState_d = W_DATA;
          wAddr_d  = in.awaddr;
          wLen_d   = in.awlen;
          wSize_d  = in.awsize;
          wBurst_d = in.awburst;
          wBeats_d = 9'd0;
          wErr_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (in.wvalid) begin
          memWe    = wBeatInRange;
          wBeats_d = wBeatsNext;
          wErr_d   = wErr_q | ~wBeatInRange;
          wAddr_d  = nextAddr(wAddr_q, wLen_q, wSize_q, wBurst_q);
          if (in.wlast) begin
            wState_d = W_RESP;
            bResp_d  = ((wBeatsNext != ({1'b0, wLen_q} + 9'd1)) || wErr_q || !wBeatInRange)
                       ? 2'b10 : 2'b00;
          end
        end
      end
      W_RESP: begin
        if (bHs) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // State and datapath registers for both channels; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rState_q <= R_IDLE;
      rAddr_q  <= '0;
      rLen_q   <= '0;
      rSize_q  <= '0;
      rBurst_q <= '0;
      rCnt_q   <= '0;
      rData_q  <= '0;
      rResp_q  <= '0;
      wState_q <= W_IDLE;
      wAddr_q  <= '0;
      wLen_q   <= '0;
      wSize_q  <= '0;
      wBurst_q <= '0;
      wBeats_q <= '0;
      wErr_q   <= 1'b0;
      bResp_q  <= '0;
    end else begin
      rState_q <= rState_d;
      rAddr_q  <= rAddr_d;
      rLen_q   <= rLen_d;
      rSize_q  <= rSize_d;
      rBurst_q <= rBurst_d;
      rCnt_q   <= rCnt_d;
      rData_q  <= rData_d;
      rResp_q  <= rResp_d;
      wState_q <= wState_d;
      wAddr_q  <= wAddr_d;
      wLen_q   <= wLen_d;
      wSize_q  <= wSize_d;
      wBurst_q <= wBurst_d;
      wBeats_q <= wBeats_d;
      wErr_q   <= wErr_d;
      bResp_q  <= bResp_d;
    end
  end

  // Storage is deliberately outside reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < BYTES; b++) begin
        if (in.wstrb[b]) mem[wordIdx(wAddr_q)][8*b +: 8] <= in.wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_npc_axi_ram.sv
// Self-checking bench for npc_axi_ram: reset values, a table of single-beat
// write/read vectors, hand-written burst and reset sequences, and random bursts
// compared with a word-array reference model.
module tb_npc_axi_ram;
  localparam int          DW    = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LIMIT = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  axi_if #(.DATA_W(DW)) bus();

  npc_axi_ram #(.DATA_W(DW), .DEPTH_LOG2(16), .BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .in  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] expData;
    logic [1:0]  expRresp;
    logic [1:0]  expBresp;
  } vec_t;

  vec_t        vecs[8];
  int          checkCount = 0;
  int          passCount  = 0;
  logic [63:0] wrData[16];
  logic [7:0]  wrStrb[16];
  logic [63:0] rdData[16];
  logic [1:0]  rdResp[16];
  logic        rdLast[16];
  int          rdWait[16];
  logic [63:0] model [int];
  logic [63:0] dWord[4];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int nBeats, output logic [1:0] resp);
    int t;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = 3'd3;
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < LIMIT) begin waitEdge(); t++; end
    checkOutput("aw_handshake", bus.awready, 1);
    waitEdge();
    bus.awvalid = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      bus.wdata  = wrData[i];
      bus.wstrb  = wrStrb[i];
      bus.wlast  = (i == nBeats - 1);
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < LIMIT) begin waitEdge(); t++; end
      checkOutput("w_handshake", bus.wready, 1);
      waitEdge();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < LIMIT) begin waitEdge(); t++; end
    checkOutput("b_handshake", bus.bvalid, 1);
    resp = bus.bresp;
    waitEdge();
    bus.bready = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input int nBeats);
    int t;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = 3'd3;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < LIMIT) begin waitEdge(); t++; end
    checkOutput("ar_handshake", bus.arready, 1);
    waitEdge();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int i = 0; i < nBeats; i++) begin
      t = 0;
      while (!bus.rvalid && t < LIMIT) begin waitEdge(); t++; end
      checkOutput("r_handshake", bus.rvalid, 1);
      rdWait[i] = t;
      rdData[i] = bus.rdata;
      rdResp[i] = bus.rresp;
      rdLast[i] = bus.rlast;
      waitEdge();
    end
    bus.rready = 1'b0;
  endtask

  // One table entry: single-beat write, then single-beat read of the same address.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [1:0] resp;
    wrData[0] = v.wdata;
    wrStrb[0] = v.wstrb;
    axiWrite(v.addr, 8'd0, 2'b01, 1, resp);
    checkOutput($sformatf("vec%0d_bresp", idx), resp, v.expBresp);
    axiRead(v.addr, 8'd0, 2'b01, 1);
    checkOutput($sformatf("vec%0d_rdata", idx), rdData[0], v.expData);
    checkOutput($sformatf("vec%0d_rresp", idx), rdResp[0], v.expRresp);
    checkOutput($sformatf("vec%0d_rlast", idx), rdLast[0], 1);
  endtask

  // Beat address computed from the burst rules with plain arithmetic on byte offsets.
  function automatic logic [31:0] modelAddr(input logic [31:0] start, input int len,
                                            input int burst, input int i);
    int off;
    int span;
    int blk;
    off = int'(start - BASE);
    if (burst == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      span = (len + 1) * 8;
      blk  = (off / span) * span;
      return BASE + 32'(blk + ((off - blk + i * 8) % span));
    end
    return start + 32'(i * 8);
  endfunction

  function automatic void modelWrite(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] w;
    int          k;
    k = int'((a - BASE) / 8);
    w = model.exists(k) ? model[k] : 64'd0;
    for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model[k] = w;
  endfunction

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    int          lens[7];
    int          len;
    int          burst;
    int          startIdx;
    logic [31:0] start;

    bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;

    vecs[0] = '{32'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h1122334455667788, 2'b00, 2'b00};
    vecs[1] = '{32'h8000_0020, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 2'b00, 2'b00};
    vecs[2] = '{32'h8000_0020, 64'h0,                8'h0F, 64'hFFFFFFFF00000000, 2'b00, 2'b00};
    vecs[3] = '{32'h8000_0020, 64'h0123456789ABCDEF, 8'hF0, 64'h0123456700000000, 2'b00, 2'b00};
    vecs[4] = '{32'h8007_FFF8, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'hDEADBEEFCAFEF00D, 2'b00, 2'b00};
    vecs[5] = '{32'h8007_FFF8, 64'h1100000000000000, 8'h80, 64'h11ADBEEFCAFEF00D, 2'b00, 2'b00};
    vecs[6] = '{32'h8008_0000, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h0,                2'b10, 2'b10};
    vecs[7] = '{32'h7FFF_FFF8, 64'h5555555555555555, 8'hFF, 64'h0,                2'b10, 2'b10};

    // Reset values while rst is held.
    #2;
    checkOutput("rst_arready", bus.arready, 1);
    checkOutput("rst_awready", bus.awready, 1);
    checkOutput("rst_wready",  bus.wready,  0);
    checkOutput("rst_rvalid",  bus.rvalid,  0);
    checkOutput("rst_rlast",   bus.rlast,   0);
    checkOutput("rst_bvalid",  bus.bvalid,  0);
    checkOutput("rst_rdata",   bus.rdata,   0);
    checkOutput("rst_rresp",   bus.rresp,   0);
    checkOutput("rst_bresp",   bus.bresp,   0);
    waitEdge();
    waitEdge();
    rst = 1'b0;
    waitEdge();

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // INCR burst write then back-to-back INCR read.
    for (int i = 0; i < 4; i++) begin
      dWord[i]  = 64'hA0A0_0000_0000_0000 + 64'(i * 64'h1_0000_0101);
      wrData[i] = dWord[i];
      wrStrb[i] = 8'hFF;
    end
    axiWrite(BASE, 8'd3, 2'b01, 4, resp);
    checkOutput("incr_w_bresp", resp, 2'b00);
    axiRead(BASE, 8'd3, 2'b01, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("incr_r_data%0d", i), rdData[i], dWord[i]);
      checkOutput($sformatf("incr_r_last%0d", i), rdLast[i], (i == 3));
      checkOutput($sformatf("incr_r_wait%0d", i), rdWait[i], 0);
    end

    // WRAP from offset 0x18 visits 0x18, 0x00, 0x08, 0x10.
    axiRead(BASE + 32'h18, 8'd3, 2'b10, 4);
    checkOutput("wrap_b0", rdData[0], dWord[3]);
    checkOutput("wrap_b1", rdData[1], dWord[0]);
    checkOutput("wrap_b2", rdData[2], dWord[1]);
    checkOutput("wrap_b3", rdData[3], dWord[2]);

    // WRAP with len 2 is not a legal wrap length and proceeds as INCR.
    axiRead(BASE + 32'h08, 8'd2, 2'b10, 3);
    checkOutput("wrap3_b0", rdData[0], dWord[1]);
    checkOutput("wrap3_b1", rdData[1], dWord[2]);
    checkOutput("wrap3_b2", rdData[2], dWord[3]);

    // FIXED burst repeats one word.
    axiRead(BASE + 32'h08, 8'd1, 2'b00, 2);
    checkOutput("fixed_b0", rdData[0], dWord[1]);
    checkOutput("fixed_b1", rdData[1], dWord[1]);

    // Early wlast: awlen 3 but only three beats.
    for (int i = 0; i < 3; i++) begin wrData[i] = 64'hC0DE_0000 + 64'(i); wrStrb[i] = 8'hFF; end
    axiWrite(BASE + 32'h40, 8'd3, 2'b01, 3, resp);
    checkOutput("short_bresp", resp, 2'b10);
    axiRead(BASE + 32'h48, 8'd0, 2'b01, 1);
    checkOutput("short_data1", rdData[0], 64'hC0DE_0001);

    // Same-edge read and write of one word returns the pre-write data.
    wrData[0] = 64'h5A5A_5A5A_0000_1111;
    wrStrb[0] = 8'hFF;
    fork
      axiWrite(BASE, 8'd0, 2'b01, 1, resp);
      begin
        waitEdge();
        axiRead(BASE, 8'd0, 2'b01, 1);
      end
    join
    checkOutput("rw_same_old", rdData[0], dWord[0]);
    axiRead(BASE, 8'd0, 2'b01, 1);
    checkOutput("rw_same_new", rdData[0], 64'h5A5A_5A5A_0000_1111);

    // Stalled read holds its beat, then reset mid-burst drops it at once.
    bus.araddr = BASE + 32'h08; bus.arlen = 8'd3; bus.arsize = 3'd3; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    waitEdge();
    bus.arvalid = 1'b0;
    waitEdge();
    waitEdge();
    checkOutput("stall_rvalid", bus.rvalid, 1);
    checkOutput("stall_rdata",  bus.rdata,  dWord[1]);
    checkOutput("stall_rlast",  bus.rlast,  0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_rvalid",  bus.rvalid,  0);
    checkOutput("midrst_arready", bus.arready, 1);
    waitEdge();
    rst = 1'b0;
    waitEdge();
    axiRead(BASE + 32'h08, 8'd0, 2'b01, 1);
    checkOutput("postrst_data", rdData[0], dWord[1]);
    checkOutput("postrst_last", rdLast[0], 1);

    // Random bursts in a 64-word region, checked against the reference model.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 16; i++) begin
        wrData[i] = {$urandom, $urandom};
        wrStrb[i] = 8'hFF;
        modelWrite(BASE + 32'((256 + blk * 16 + i) * 8), wrData[i], 8'hFF);
      end
      axiWrite(BASE + 32'((256 + blk * 16) * 8), 8'd15, 2'b01, 16, resp);
      checkOutput("rnd_init_bresp", resp, 2'b00);
    end
    lens = '{0, 1, 2, 3, 5, 7, 15};
    for (int op = 0; op < 40; op++) begin
      len      = lens[$urandom_range(0, 6)];
      burst    = $urandom_range(0, 2);
      startIdx = 256 + $urandom_range(0, 63 - len);
      start    = BASE + 32'(startIdx * 8);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wrData[i] = {$urandom, $urandom};
          wrStrb[i] = 8'($urandom);
          modelWrite(modelAddr(start, len, burst, i), wrData[i], wrStrb[i]);
        end
        axiWrite(start, 8'(len), 2'(burst), len + 1, resp);
        checkOutput($sformatf("rnd%0d_bresp", op), resp, 2'b00);
      end else begin
        axiRead(start, 8'(len), 2'(burst), len + 1);
        for (int i = 0; i <= len; i++) begin
          checkOutput($sformatf("rnd%0d_b%0d_data", op, i), rdData[i],
                      model[int'((modelAddr(start, len, burst, i) - BASE) / 8)]);
          checkOutput($sformatf("rnd%0d_b%0d_last", op, i), rdLast[i], (i == len));
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
